// File: rtl/lcd_spi_byte_tx.sv
// LCD SPI byte transmitter: one byte + D/C flag per valid/ready handshake, shifted MSB-first; `LCD_SPI_MODE3_EN selects SCLK idle-high.
// Latency: first SCLK rising edge CLK_DIV cycles after accept; 16*CLK_DIV cycles per byte, 17*CLK_DIV to CS high for an isolated byte.
// Backpressure: tx_ready only in IDLE or on the last-bit boundary cycle; tx_valid need not be held.
module lcd_spi_byte_tx #(
    parameter int CLK_DIV = 1
) (
    input  logic       clk_25MHz,
    input  logic       rst_n,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_dc,
    output logic       busy,
    output logic       lcd_cs,
    output logic       lcd_dc,
    output logic       lcd_sclk,
    output logic       lcd_mosi
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

`ifdef LCD_SPI_MODE3_EN
    localparam logic SCLK_IDLE = 1'b1;
`else
    localparam logic SCLK_IDLE = 1'b0;
`endif

    logic [1:0]       state_q,   state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             phase_q,   phase_d;
    // Only the bits still to be sent; bit 7 goes straight to lcd_mosi on load.
    logic [6:0]       shift_q,   shift_d;
    logic             cs_q,      cs_d;
    logic             dc_q,      dc_d;
    logic             sclk_q,    sclk_d;
    logic             mosi_q,    mosi_d;

    logic tick;
    logic last_bit;
    logic load;

    assign tick     = (div_cnt_q == DIV_LAST);
    assign last_bit = (state_q == ST_SHIFT) && phase_q && tick && (bit_cnt_q == 3'd7);
    assign tx_ready = (state_q == ST_IDLE) || last_bit;
    assign load     = tx_valid && tx_ready;
    assign busy     = (state_q != ST_IDLE);

    assign lcd_cs   = cs_q;
    assign lcd_dc   = dc_q;
    assign lcd_sclk = sclk_q;
    assign lcd_mosi = mosi_q;

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        phase_d   = phase_q;
        shift_d   = shift_q;
        cs_d      = cs_q;
        dc_d      = dc_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;

        if (state_q != ST_IDLE) begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        sclk_d  = 1'b1;
                    end else if (bit_cnt_q != 3'd7) begin
                        sclk_d    = 1'b0;
                        mosi_d    = shift_q[6];
                        shift_d   = {shift_q[5:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        phase_d   = 1'b0;
                    end else if (!tx_valid) begin
                        sclk_d  = 1'b0;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    cs_d    = 1'b1;
                    sclk_d  = SCLK_IDLE;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A load overrides everything: from IDLE, or back-to-back at the last-bit boundary.
        if (load) begin
            shift_d   = tx_data[6:0];
            mosi_d    = tx_data[7];
            dc_d      = tx_dc;
            cs_d      = 1'b0;
            sclk_d    = 1'b0;
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
            div_cnt_d = '0;
            state_d   = ST_SHIFT;
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= 3'd0;
            phase_q   <= 1'b0;
            shift_q   <= 7'd0;
            cs_q      <= 1'b1;
            dc_q      <= 1'b0;
            sclk_q    <= SCLK_IDLE;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            phase_q   <= phase_d;
            shift_q   <= shift_d;
            cs_q      <= cs_d;
            dc_q      <= dc_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

endmodule

// File: tb/tb_lcd_spi_byte_tx.sv
// Bench for lcd_spi_byte_tx: stimulus pushes {dc,byte} on each handshake, a pin monitor rebuilds bytes and checks SPI timing.
module tb_lcd_spi_byte_tx;

    localparam int DIV = 2;
`ifdef LCD_SPI_MODE3_EN
    localparam logic SCLK_IDLE = 1'b1;
`else
    localparam logic SCLK_IDLE = 1'b0;
`endif

    logic       clk_25MHz = 1'b0;
    logic       rst_n     = 1'b0;
    logic       tx_valid  = 1'b0;
    logic [7:0] tx_data   = 8'h00;
    logic       tx_dc     = 1'b0;
    logic       tx_ready;
    logic       busy;
    logic       lcd_cs;
    logic       lcd_dc;
    logic       lcd_sclk;
    logic       lcd_mosi;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    lcd_spi_byte_tx #(.CLK_DIV(DIV)) dut (
        .clk_25MHz (clk_25MHz),
        .rst_n     (rst_n),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_dc     (tx_dc),
        .busy      (busy),
        .lcd_cs    (lcd_cs),
        .lcd_dc    (lcd_dc),
        .lcd_sclk  (lcd_sclk),
        .lcd_mosi  (lcd_mosi)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Offer one byte; push the expectation at the handshake edge.
    task automatic send(input logic [7:0] d, input logic dc, input bit hold);
        int t;
        @(negedge clk_25MHz);
        tx_valid = 1'b1;
        tx_data  = d;
        tx_dc    = dc;
        t = 0;
        while (!tx_ready && t < 40 * DIV) begin
            @(negedge clk_25MHz);
            t++;
        end
        if (!tx_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: actual no tx_ready required tx_ready within %0d cycles", 40 * DIV);
        end else begin
            exp_q.push_back({dc, d});
        end
        @(posedge clk_25MHz);
        #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk_25MHz);
        while (busy && t < 100 * DIV) begin
            @(negedge clk_25MHz);
            t++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: actual busy required idle within %0d cycles", 100 * DIV);
        end
    endtask

    // Pin monitor: samples on the falling clock edge.
    initial begin
        logic       prev_cs, prev_sclk, prev_mosi, prev_dc;
        logic [7:0] sh;
        logic [8:0] e;
        logic       bdc, dc_ok;
        int         bits, win_len, win_bytes, last_rise;
        bit         win_valid, got_first;
        prev_cs = 1'b1; prev_sclk = SCLK_IDLE; prev_mosi = 1'b0; prev_dc = 1'b0;
        sh = 8'h00; e = 9'h000; bdc = 1'b0; dc_ok = 1'b1;
        bits = 0; win_len = 0; win_bytes = 0; last_rise = 0;
        win_valid = 1'b0; got_first = 1'b0;
        forever begin
            @(negedge clk_25MHz);
            if (!rst_n) begin
                prev_cs = 1'b1; prev_sclk = SCLK_IDLE;
                bits = 0; win_valid = 1'b0; dc_ok = 1'b1;
            end else begin
                if (prev_cs && !lcd_cs) begin
                    win_valid = 1'b1; win_len = 0; win_bytes = 0;
                    got_first = 1'b0; bits = 0; dc_ok = 1'b1;
                    chk("load_sclk_low", int'(lcd_sclk), 0);
                    chk("busy_on_load", int'(busy), 1);
                end
                if (!lcd_cs && win_valid) begin
                    win_len++;
                    if (!prev_cs && prev_sclk && lcd_sclk)
                        chk("stable_while_sclk_high", int'({lcd_mosi, lcd_dc}), int'({prev_mosi, prev_dc}));
                    if (!prev_sclk && lcd_sclk) begin
                        if (!got_first) chk("setup_cycles", win_len - 1, DIV);
                        else            chk("sclk_period", win_len - last_rise, 2 * DIV);
                        last_rise = win_len;
                        got_first = 1'b1;
                        if (bits == 0) bdc = lcd_dc;
                        else if (lcd_dc != bdc) dc_ok = 1'b0;
                        sh = {sh[6:0], lcd_mosi};
                        bits++;
                        if (bits == 8) begin
                            bits = 0;
                            win_bytes++;
                            if (exp_q.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL byte_unexpected: actual 0x%02h required none", sh);
                            end else begin
                                e = exp_q.pop_front();
                                chk("byte", int'(sh), int'(e[7:0]));
                                chk("dc", int'({dc_ok, bdc}), int'({1'b1, e[8]}));
                            end
                            dc_ok = 1'b1;
                        end
                    end
                end
                if (!prev_cs && lcd_cs && win_valid) begin
                    chk("cs_window", win_len, (16 * win_bytes + 1) * DIV);
                    chk("idle_sclk", int'(lcd_sclk), int'(SCLK_IDLE));
                    chk("busy_off", int'(busy), 0);
                    chk("partial_bits", bits, 0);
                    win_valid = 1'b0;
                end
                prev_cs = lcd_cs; prev_sclk = lcd_sclk;
                prev_mosi = lcd_mosi; prev_dc = lcd_dc;
            end
        end
    end

    initial begin
        bit hold;
        repeat (3) @(posedge clk_25MHz);
        @(negedge clk_25MHz);
        chk("rst_cs", int'(lcd_cs), 1);
        chk("rst_sclk", int'(lcd_sclk), int'(SCLK_IDLE));
        rst_n = 1'b1;
        @(negedge clk_25MHz);
        chk("rst_mosi", int'(lcd_mosi), 0);
        chk("rst_dc", int'(lcd_dc), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(tx_ready), 1);

        send(8'hA5, 1'b0, 1'b0);
        wait_idle();

        send(8'h2C, 1'b0, 1'b1);
        send(8'hFF, 1'b1, 1'b1);
        send(8'h00, 1'b1, 1'b0);
        wait_idle();

        // Valid arrives just after the last-bit boundary: HOLD must be taken.
        send(8'h5A, 1'b1, 1'b0);
        repeat (16 * DIV) @(posedge clk_25MHz);
        @(negedge clk_25MHz);
        chk("ready_in_hold", int'(tx_ready), 0);
        chk("cs_in_hold", int'(lcd_cs), 0);
        send(8'h96, 1'b0, 1'b0);
        wait_idle();

        // Reset in the middle of 0x81, then a clean byte.
        send(8'h81, 1'b1, 1'b0);
        repeat (9 * DIV) @(posedge clk_25MHz);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_cs", int'(lcd_cs), 1);
        chk("midrst_sclk", int'(lcd_sclk), int'(SCLK_IDLE));
        chk("midrst_mosi", int'(lcd_mosi), 0);
        chk("midrst_dc", int'(lcd_dc), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(tx_ready), 1);
        exp_q.delete();
        @(negedge clk_25MHz);
        @(negedge clk_25MHz);
        rst_n = 1'b1;
        send(8'h3C, 1'b0, 1'b0);
        wait_idle();

        send(8'h0F, 1'b0, 1'b0);
        wait_idle();

        for (int i = 0; i < 300; i++) begin
            hold = ($urandom_range(0, 2) == 0) && (i != 299);
            send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), hold);
            if (!hold) repeat ($urandom_range(0, 40)) @(negedge clk_25MHz);
        end
        wait_idle();
        repeat (4) @(negedge clk_25MHz);
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
